ssd_digit_scheduler: RTL and testbench

Sequences the two-digit Pmod seven-segment display from keypad events. Captures each accepted key code into a two-digit shift register (right digit newest), applies release-qualified re-arming so a held key is entered once, and time-multiplexes the shared segment bus with blanking between digit switches to prevent ghosting. Sits between keypad_decoder and disp_ctrl. Drives disp_ctrl's disp_val input and the board chip_sel pin.

---
 rtl/ssd_sched_pkg.sv | 30 +++
 rtl/key_release_filter.sv | 56 +++++
 rtl/ssd_digit_scheduler.sv | 115 +++++++++++
 tb/tb_ssd_digit_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_sched_pkg.sv
// rtl/ssd_sched_pkg.sv - shared types, select constants and timing defaults for the digit scheduler
package ssd_sched_pkg;

    typedef enum logic [1:0] {
        SHOW_R     = 2'd0,
        BLANK_TO_L = 2'd1,
        SHOW_L     = 2'd2,
        BLANK_TO_R = 2'd3
    } mux_state_t;

    typedef enum logic [1:0] {
        ARMED     = 2'd0,
        HELD      = 2'd1,
        RELEASING = 2'd2
    } key_state_t;

    localparam logic SEL_RIGHT = 1'b0;
    localparam logic SEL_LEFT  = 1'b1;

    // Defaults for a 125 MHz system clock
    localparam int DEF_DWELL_CYCLES   = 312_500;
    localparam int DEF_BLANK_CYCLES   = 1_250;
    localparam int DEF_RELEASE_CYCLES = 125_000;

    // Counter width able to hold 0..n-1; a count of 1 still needs one bit
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_release_filter.sv
// rtl/key_release_filter.sv - key acceptance FSM that re-arms only after a sustained release
module key_release_filter
    import ssd_sched_pkg::*;
#(
    parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_valid,
    output logic accept
);

    localparam int RW = cnt_width(RELEASE_CYCLES);
    localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYCLES - 1);

    key_state_t      state;
    logic [RW-1:0]   rel_cnt;

    // A key is taken exactly once, on the first cycle it is seen while armed
    assign accept = (state == ARMED) && key_valid;

    // Key state machine with release counter; short lows count as bounce and re-enter HELD
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARMED;
            rel_cnt <= '0;
        end else begin
            case (state)
                ARMED: begin
                    rel_cnt <= '0;
                    if (key_valid) state <= HELD;
                end
                HELD: begin
                    rel_cnt <= '0;
                    if (!key_valid) state <= RELEASING;
                end
                RELEASING: begin
                    if (key_valid) begin
                        state   <= HELD;
                        rel_cnt <= '0;
                    end else if (rel_cnt == REL_LAST) begin
                        state   <= ARMED;
                        rel_cnt <= '0;
                    end else begin
                        rel_cnt <= rel_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ARMED;
                    rel_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ssd_digit_scheduler.sv
// rtl/ssd_digit_scheduler.sv - two-digit capture register and blanked display multiplexer
module ssd_digit_scheduler
    import ssd_sched_pkg::*;
#(
    parameter int DWELL_CYCLES   = DEF_DWELL_CYCLES,
    parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES,
    parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       mode_manual,
    input  logic       sel_toggle,
    input  logic       clear,
    output logic [3:0] disp_val,
    output logic       disp_en,
    output logic       chip_sel,
    output logic [3:0] left_digit,
    output logic [3:0] right_digit,
    output logic       new_key
);

    localparam int MAXP = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int MW   = cnt_width(MAXP);
    localparam logic [MW-1:0] DWELL_LAST = MW'(DWELL_CYCLES - 1);
    localparam logic [MW-1:0] BLANK_LAST = MW'(BLANK_CYCLES - 1);

    logic          accept;
    mux_state_t    mux_state;
    logic [MW-1:0] mux_cnt;
    logic          show_done;

    key_release_filter #(
        .RELEASE_CYCLES(RELEASE_CYCLES)
    ) u_key_filter (
        .clk      (clk),
        .rst      (rst),
        .key_valid(key_valid),
        .accept   (accept)
    );

    // A SHOW state ends on a toggle in manual mode, or after the dwell in auto mode
    always_comb begin
        show_done = 1'b0;
        if (mode_manual) show_done = sel_toggle;
        else             show_done = (mux_cnt == DWELL_LAST);
    end

    // Display multiplexer: chip_sel flips together with the start of a blank window
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_state <= SHOW_R;
            mux_cnt   <= '0;
            chip_sel  <= SEL_RIGHT;
            disp_en   <= 1'b1;
        end else begin
            case (mux_state)
                SHOW_R, SHOW_L: begin
                    disp_en <= 1'b1;
                    if (show_done) begin
                        mux_state <= (mux_state == SHOW_R) ? BLANK_TO_L : BLANK_TO_R;
                        chip_sel  <= (mux_state == SHOW_R) ? SEL_LEFT : SEL_RIGHT;
                        disp_en   <= 1'b0;
                        mux_cnt   <= '0;
                    end else if (mode_manual) begin
                        mux_cnt <= '0;
                    end else begin
                        mux_cnt <= mux_cnt + 1'b1;
                    end
                end
                BLANK_TO_L, BLANK_TO_R: begin
                    if (mux_cnt == BLANK_LAST) begin
                        mux_state <= (mux_state == BLANK_TO_L) ? SHOW_L : SHOW_R;
                        disp_en   <= 1'b1;
                        mux_cnt   <= '0;
                    end else begin
                        disp_en <= 1'b0;
                        mux_cnt <= mux_cnt + 1'b1;
                    end
                end
                default: begin
                    mux_state <= SHOW_R;
                    chip_sel  <= SEL_RIGHT;
                    disp_en   <= 1'b1;
                    mux_cnt   <= '0;
                end
            endcase
        end
    end

    // Digit shift register; clear overrides a simultaneous capture and suppresses new_key
    always_ff @(posedge clk) begin
        if (rst) begin
            left_digit  <= 4'h0;
            right_digit <= 4'h0;
            new_key     <= 1'b0;
            disp_val    <= 4'h0;
        end else begin
            if (clear) begin
                left_digit  <= 4'h0;
                right_digit <= 4'h0;
                new_key     <= 1'b0;
            end else if (accept) begin
                left_digit  <= right_digit;
                right_digit <= key_code;
                new_key     <= 1'b1;
            end else begin
                new_key <= 1'b0;
            end
            disp_val <= (chip_sel == SEL_LEFT) ? left_digit : right_digit;
        end
    end

endmodule

// File: tb/tb_ssd_digit_scheduler.sv
// tb/tb_ssd_digit_scheduler.sv - self-checking bench for ssd_digit_scheduler
module tb_ssd_digit_scheduler;

    localparam int DW  = 8;
    localparam int BL  = 2;
    localparam int RL  = 4;
    localparam int PER = 2 * (DW + BL);

    logic       clk = 1'b0;
    logic       rst, key_valid, mode_manual, sel_toggle, clear;
    logic [3:0] key_code;
    logic [3:0] disp_val, left_digit, right_digit;
    logic       disp_en, chip_sel, new_key;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ssd_digit_scheduler #(
        .DWELL_CYCLES  (DW),
        .BLANK_CYCLES  (BL),
        .RELEASE_CYCLES(RL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .mode_manual(mode_manual),
        .sel_toggle (sel_toggle),
        .clear      (clear),
        .disp_val   (disp_val),
        .disp_en    (disp_en),
        .chip_sel   (chip_sel),
        .left_digit (left_digit),
        .right_digit(right_digit),
        .new_key    (new_key)
    );

    // Reference model (auto mode): refresh position within one 20-cycle period,
    // armed flag and count of consecutive low samples since the last high.
    bit       m_armed;
    int       m_low;
    int       m_p;
    logic [3:0] m_l, m_r, m_dv;
    bit       m_nk;

    function automatic bit exp_sel(input int p);
        return (p >= DW) && (p < 2 * DW + BL);
    endfunction

    function automatic bit exp_en(input int p);
        return !((p >= DW && p < DW + BL) || (p >= 2 * DW + BL));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge with the inputs currently driven, then the model catches up
    task automatic cyc();
        bit acc;
        @(posedge clk);
        #1;
        if (rst) begin
            m_armed = 1; m_low = 0; m_p = 0;
            m_l = 0; m_r = 0; m_dv = 0; m_nk = 0;
        end else begin
            m_dv = exp_sel(m_p) ? m_l : m_r;
            acc  = m_armed && key_valid;
            if (acc) begin
                m_armed = 0;
                m_low   = 0;
            end else if (!m_armed) begin
                if (key_valid) m_low = 0;
                else begin
                    m_low++;
                    if (m_low == RL + 1) m_armed = 1;
                end
            end
            if (clear) begin
                m_l = 0; m_r = 0; m_nk = 0;
            end else if (acc) begin
                m_l = m_r; m_r = key_code; m_nk = 1;
            end else begin
                m_nk = 0;
            end
            m_p = (m_p + 1) % PER;
        end
    endtask

    task automatic do_reset();
        rst = 1; key_valid = 0; clear = 0; sel_toggle = 0;
        cyc();
        rst = 0;
    endtask

    typedef struct {
        logic       kv;
        logic [3:0] code;
        logic       clr;
        logic [3:0] exp_r;
        logic [3:0] exp_l;
        logic       exp_nk;
    } vec_t;

    vec_t vt[12];
    int   nk_count;
    bit   steady;

    initial begin
        rst = 1; key_valid = 0; key_code = 0; mode_manual = 0; sel_toggle = 0; clear = 0;

        // Table: press 5, long release, press A, bounce, then clear
        vt[0]  = '{1'b1, 4'h5, 1'b0, 4'h5, 4'h0, 1'b1};
        vt[1]  = '{1'b1, 4'h5, 1'b0, 4'h5, 4'h0, 1'b0};
        vt[2]  = '{1'b0, 4'h5, 1'b0, 4'h5, 4'h0, 1'b0};
        vt[3]  = '{1'b0, 4'h5, 1'b0, 4'h5, 4'h0, 1'b0};
        vt[4]  = '{1'b0, 4'h5, 1'b0, 4'h5, 4'h0, 1'b0};
        vt[5]  = '{1'b0, 4'h5, 1'b0, 4'h5, 4'h0, 1'b0};
        vt[6]  = '{1'b0, 4'h5, 1'b0, 4'h5, 4'h0, 1'b0};
        vt[7]  = '{1'b1, 4'hA, 1'b0, 4'hA, 4'h5, 1'b1};
        vt[8]  = '{1'b1, 4'hA, 1'b0, 4'hA, 4'h5, 1'b0};
        vt[9]  = '{1'b0, 4'hA, 1'b0, 4'hA, 4'h5, 1'b0};
        vt[10] = '{1'b1, 4'h3, 1'b0, 4'hA, 4'h5, 1'b0};
        vt[11] = '{1'b0, 4'h3, 1'b1, 4'h0, 4'h0, 1'b0};

        do_reset();
        chk("rst_chip_sel", chip_sel, 0);
        chk("rst_disp_en", disp_en, 1);
        chk("rst_disp_val", disp_val, 0);
        chk("rst_left", left_digit, 0);
        chk("rst_right", right_digit, 0);
        chk("rst_new_key", new_key, 0);

        for (int i = 0; i < 12; i++) begin
            key_valid = vt[i].kv; key_code = vt[i].code; clear = vt[i].clr;
            cyc();
            chk($sformatf("tbl%0d_right", i), right_digit, vt[i].exp_r);
            chk($sformatf("tbl%0d_left", i), left_digit, vt[i].exp_l);
            chk($sformatf("tbl%0d_new_key", i), new_key, vt[i].exp_nk);
        end
        clear = 0; key_valid = 0;

        // Held key with 2-cycle low bounces: one capture only
        do_reset();
        nk_count = 0;
        key_code = 4'h3;
        for (int i = 0; i < 50; i++) begin
            key_valid = !((i % 10) == 6 || (i % 10) == 7);
            cyc();
            if (new_key) nk_count++;
            key_code = 4'($urandom_range(0, 15));
        end
        chk("hold_captures", nk_count, 1);
        chk("hold_right", right_digit, 3);
        key_valid = 0;

        // Clear coinciding with a capture consumes the key
        do_reset();
        key_valid = 1; key_code = 4'h9; cyc();
        key_valid = 0; repeat (6) cyc();
        chk("clr_pre_right", right_digit, 9);
        key_valid = 1; key_code = 4'h7; clear = 1; cyc();
        chk("clr_right", right_digit, 0);
        chk("clr_left", left_digit, 0);
        chk("clr_new_key", new_key, 0);
        clear = 0; cyc();
        chk("clr_no_late_key", new_key, 0);
        key_valid = 0; repeat (3) cyc();
        key_valid = 1; key_code = 4'h2; cyc();
        chk("short_release_new_key", new_key, 0);
        chk("short_release_right", right_digit, 0);
        key_valid = 0; repeat (5) cyc();
        key_valid = 1; key_code = 4'h2; cyc();
        chk("rearm_new_key", new_key, 1);
        chk("rearm_right", right_digit, 2);
        key_valid = 0;

        // Manual mode: no movement without a toggle, one toggle gives a 2-cycle blank
        mode_manual = 1;
        do_reset();
        steady = 1;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (chip_sel !== 1'b0 || disp_en !== 1'b1) steady = 0;
        end
        chk("manual_steady", steady, 1);
        sel_toggle = 1; cyc(); sel_toggle = 0;
        chk("tog_blank1_sel", chip_sel, 1);
        chk("tog_blank1_en", disp_en, 0);
        cyc();
        chk("tog_blank2_sel", chip_sel, 1);
        chk("tog_blank2_en", disp_en, 0);
        cyc();
        chk("tog_show_sel", chip_sel, 1);
        chk("tog_show_en", disp_en, 1);
        steady = 1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (chip_sel !== 1'b1 || disp_en !== 1'b1) steady = 0;
        end
        chk("manual_steady_left", steady, 1);
        mode_manual = 0;

        // Reset in BLANK_TO_L
        do_reset();
        key_valid = 1; key_code = 4'h4; cyc();
        key_valid = 0; repeat (7) cyc();
        chk("pre_blank_sel", chip_sel, 1);
        chk("pre_blank_en", disp_en, 0);
        rst = 1; cyc(); rst = 0;
        chk("rstblank_sel", chip_sel, 0);
        chk("rstblank_en", disp_en, 1);
        chk("rstblank_right", right_digit, 0);
        chk("rstblank_val", disp_val, 0);
        key_valid = 1; key_code = 4'h6; cyc();
        chk("rstblank_armed", new_key, 1);
        chk("rstblank_cap", right_digit, 6);

        // Reset in RELEASING
        key_valid = 0; repeat (2) cyc();
        rst = 1; cyc(); rst = 0;
        chk("rstrel_right", right_digit, 0);
        chk("rstrel_new_key", new_key, 0);
        key_valid = 1; key_code = 4'h8; cyc();
        chk("rstrel_armed", new_key, 1);
        chk("rstrel_cap", right_digit, 8);
        key_valid = 0;

        // Randomized auto-mode run against the model
        do_reset();
        key_valid = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) key_valid = !key_valid;
            key_code = 4'($urandom_range(0, 15));
            clear    = ($urandom_range(0, 39) == 0);
            sel_toggle = $urandom_range(0, 1);
            cyc();
            chk("rnd_chip_sel", chip_sel, exp_sel(m_p));
            chk("rnd_disp_en", disp_en, exp_en(m_p));
            chk("rnd_new_key", new_key, m_nk);
            chk("rnd_left", left_digit, m_l);
            chk("rnd_right", right_digit, m_r);
            chk("rnd_disp_val", disp_val, m_dv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
